// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared constants and width helper for the TDM channel mux
package tdm_pkg;

  localparam int TIMER_W      = 16;
  localparam int MAX_NCH      = 16;
  localparam int MAX_SLOT_LEN = 256;

  // Index width that stays at least one bit wide for a single-entry range.
  function automatic int slot_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tdm_slot_timer.sv
// rtl/tdm_slot_timer.sv - free-running timer, slot cycle counter and slot index
// Optional frame_cnt output when TDM_FRAME_CNT_EN is defined.
module tdm_slot_timer
  import tdm_pkg::*;
#(
  parameter int NCH      = 2,
  parameter int SLOT_LEN = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  output logic [TIMER_W-1:0]          timer,
`ifdef TDM_FRAME_CNT_EN
  output logic [15:0]                 frame_cnt,
`endif
  output logic [slot_idx_w(NCH)-1:0]  slot
);

  localparam int SW = slot_idx_w(NCH);
  localparam int CW = slot_idx_w(SLOT_LEN);

  logic [CW-1:0] slot_cnt;
  logic          last_cnt;
  logic          last_slot;

  assign last_cnt  = (slot_cnt == CW'(SLOT_LEN - 1));
  assign last_slot = (slot == SW'(NCH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer    <= '0;
      slot_cnt <= '0;
      slot     <= '0;
    end else if (en) begin
      timer <= timer + 1'b1;
      if (last_cnt) begin
        slot_cnt <= '0;
        slot     <= last_slot ? '0 : slot + 1'b1;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end
    end
  end

`ifdef TDM_FRAME_CNT_EN
  // A frame completes on the edge where the last slot hands back to slot 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (en && last_cnt && last_slot) begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/tdm_channel_mux.sv
// rtl/tdm_channel_mux.sv - time-division channel mux with registered output
// Optional frame_cnt output when TDM_FRAME_CNT_EN is defined.
module tdm_channel_mux
  import tdm_pkg::*;
#(
  parameter int W        = 16,
  parameter int NCH      = 2,
  parameter int SLOT_LEN = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic [NCH*W-1:0]            in_data,
  input  logic [NCH-1:0]              in_valid,
  output logic [NCH-1:0]              in_ack,
  output logic [W-1:0]                out_data,
  output logic                        out_valid,
  output logic [slot_idx_w(NCH)-1:0]  out_ch,
`ifdef TDM_FRAME_CNT_EN
  output logic [15:0]                 frame_cnt,
`endif
  output logic [TIMER_W-1:0]          timer
);

  localparam int SW = slot_idx_w(NCH);

  logic [SW-1:0] slot;
  logic          sel_valid;

  tdm_slot_timer #(
    .NCH      (NCH),
    .SLOT_LEN (SLOT_LEN)
  ) u_slot_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .timer     (timer),
`ifdef TDM_FRAME_CNT_EN
    .frame_cnt (frame_cnt),
`endif
    .slot      (slot)
  );

  assign sel_valid = in_valid[slot];

  // rst_n gates the strobe so no channel is consumed while held in reset.
  always_comb begin
    in_ack = '0;
    if (rst_n && en && sel_valid) begin
      in_ack[slot] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
    end else if (en) begin
      out_ch    <= slot;
      out_valid <= sel_valid;
      out_data  <= sel_valid ? in_data[slot*W +: W] : '0;
    end
  end

endmodule

// File: tb/tb_tdm_channel_mux.sv
// tb/tb_tdm_channel_mux.sv - scoreboard bench for two tdm_channel_mux configurations
// frame_cnt checks are compiled in when TDM_FRAME_CNT_EN is defined.
module tb_tdm_channel_mux;

  typedef struct packed {
    logic [15:0] timer;
    logic [3:0]  ch;
    logic        valid;
    logic [15:0] data;
    logic [15:0] frame;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [63:0] in_data;
  logic [3:0]  in_valid;

  logic [3:0]  ack_a;
  logic [15:0] data_a, timer_a;
  logic        valid_a;
  logic [1:0]  ch_a;
  logic [2:0]  ack_b;
  logic [15:0] data_b, timer_b;
  logic        valid_b;
  logic [1:0]  ch_b;
`ifdef TDM_FRAME_CNT_EN
  logic [15:0] frame_a, frame_b;
`endif

  exp_t qa[$];
  exp_t qb[$];
  exp_t la, lb;
  int   nvec = 0;
  int   nerr = 0;
  int   ecnt = 0;
  logic mon_en, mon_rst;

  always #5 clk = ~clk;

  tdm_channel_mux #(.W(16), .NCH(4), .SLOT_LEN(1)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ack    (ack_a),
    .out_data  (data_a),
    .out_valid (valid_a),
    .out_ch    (ch_a),
`ifdef TDM_FRAME_CNT_EN
    .frame_cnt (frame_a),
`endif
    .timer     (timer_a)
  );

  tdm_channel_mux #(.W(16), .NCH(3), .SLOT_LEN(4)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .in_data   (in_data[47:0]),
    .in_valid  (in_valid[2:0]),
    .in_ack    (ack_b),
    .out_data  (data_b),
    .out_valid (valid_b),
    .out_ch    (ch_b),
`ifdef TDM_FRAME_CNT_EN
    .frame_cnt (frame_b),
`endif
    .timer     (timer_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  // Expected registered output after edge number e (0-based count of enabled edges since reset).
  function automatic exp_t mk(input int e, input int nch, input int sl,
                              input logic [3:0] v, input logic [63:0] d);
    exp_t t;
    int   c;
    c       = (e / sl) % nch;
    t.timer = 16'(e + 1);
    t.ch    = 4'(c);
    t.valid = v[c];
    t.data  = v[c] ? d[c*16 +: 16] : 16'd0;
    t.frame = 16'((e + 1) / (sl * nch));
    return t;
  endfunction

  task automatic step(input logic e, input logic [3:0] v, input logic [63:0] d);
    logic [3:0] ea, eb;
    int         ca, cb;
    @(negedge clk);
    en = e; in_valid = v; in_data = d;
    #1;
    ca = ecnt % 4;
    cb = (ecnt / 4) % 3;
    ea = e ? (v & (4'b0001 << ca)) : 4'b0000;
    eb = e ? (v & 4'b0111 & (4'b0001 << cb)) : 4'b0000;
    chk("a_in_ack", {28'd0, ack_a}, {28'd0, ea});
    chk("b_in_ack", {29'd0, ack_b}, {28'd0, eb});
    if (e) begin
      qa.push_back(mk(ecnt, 4, 1, v, d));
      qb.push_back(mk(ecnt, 3, 4, v, d));
      ecnt++;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_a_timer"}, {16'd0, timer_a}, 32'd0);
    chk({tag, "_a_data"},  {16'd0, data_a},  32'd0);
    chk({tag, "_a_valid"}, {31'd0, valid_a}, 32'd0);
    chk({tag, "_a_ch"},    {30'd0, ch_a},    32'd0);
    chk({tag, "_a_ack"},   {28'd0, ack_a},   32'd0);
    chk({tag, "_b_timer"}, {16'd0, timer_b}, 32'd0);
    chk({tag, "_b_data"},  {16'd0, data_b},  32'd0);
    chk({tag, "_b_ch"},    {30'd0, ch_b},    32'd0);
    chk({tag, "_b_ack"},   {29'd0, ack_b},   32'd0);
  endtask

  // Monitor: every edge, pop the expectation for enabled edges, otherwise expect held values.
  always begin
    @(posedge clk);
    mon_en  = en;
    mon_rst = rst_n;
    #1;
    if (!mon_rst) begin
      la = '0;
      lb = '0;
    end else if (mon_en) begin
      if (qa.size() == 0 || qb.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL scoreboard_empty: got %0d/%0d entries, required >0", qa.size(), qb.size());
      end else begin
        la = qa.pop_front();
        lb = qb.pop_front();
      end
    end
    chk("a_timer", {16'd0, timer_a}, {16'd0, la.timer});
    chk("a_ch",    {30'd0, ch_a},    {28'd0, la.ch});
    chk("a_valid", {31'd0, valid_a}, {31'd0, la.valid});
    chk("a_data",  {16'd0, data_a},  {16'd0, la.data});
    chk("b_timer", {16'd0, timer_b}, {16'd0, lb.timer});
    chk("b_ch",    {30'd0, ch_b},    {28'd0, lb.ch});
    chk("b_valid", {31'd0, valid_b}, {31'd0, lb.valid});
    chk("b_data",  {16'd0, data_b},  {16'd0, lb.data});
`ifdef TDM_FRAME_CNT_EN
    chk("a_frame", {16'd0, frame_a}, {16'd0, la.frame});
    chk("b_frame", {16'd0, frame_b}, {16'd0, lb.frame});
`endif
  end

  localparam logic [63:0] D0 = {16'd300, 16'd200, 16'd100, 16'd0};

  initial begin
    rst_n    = 1'b0;
    en       = 1'b1;
    in_valid = 4'b1111;
    in_data  = D0;
    #3;
    check_zero("reset");
    @(negedge clk);
    @(negedge clk);
    en    = 1'b0;
    rst_n = 1'b1;
    ecnt  = 0;

    // All channels valid: A alternates through 0,100,200,300; B holds each channel 4 cycles.
    for (int i = 0; i < 6; i++) step(1'b1, 4'b1111, D0);
    // Stall mid-slot of B: everything frozen, no acks.
    for (int i = 0; i < 5; i++) step(1'b0, 4'b1111, D0);
    // Channel 2 invalid: its slot yields valid=0, data=0 and no ack.
    for (int i = 0; i < 4; i++) step(1'b1, 4'b1011, D0);

    // Asynchronous reset between edges while B is partway through slot 2.
    @(negedge clk);
    en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    ecnt  = 0;

    // Two runs with identical enable pattern and random data; schedule must repeat exactly.
    for (int run = 0; run < 2; run++) begin
      for (int i = 0; i < 26; i++) begin
        step((i % 9) != 4, 4'($urandom_range(0, 15)),
             {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)});
      end
      @(negedge clk);
      en = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check_zero("run_rst");
      @(negedge clk);
      rst_n = 1'b1;
      ecnt  = 0;
    end

    repeat (3) @(negedge clk);
    chk("qa_drained", qa.size(), 32'd0);
    chk("qb_drained", qb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
